// File: rtl/controlador_entrada.sv
`timescale 1ns/1ps
// controlador_entrada
// Producer side of the CPU WAIT/READY input handshake. Synchronises and
// debounces the raw confirm button, latches the switches on a clean press,
// and holds READY plus the latched word until the CPU drops WAIT. A button
// must be released and debounced before it can answer another request.

module controlador_entrada #(
  parameter int DEB_CICLOS = 500000,
  parameter int CNT_LARG   = 20
) (
  input  logic        clk_rapido,
  input  logic        reset,
  input  logic        confirma,
  input  logic [15:0] switches,
  input  logic        WAIT,
  output logic        READY,
  output logic [31:0] dado_entrada,
  output logic [7:0]  n_leituras,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    AGUARDA_PRESS  = 3'd1,
    DEBOUNCE       = 3'd2,
    ENTREGA        = 3'd3,
    AGUARDA_SOLTAR = 3'd4
  } estado_t;

  // Terminal count of the debounce counter: the input has been stable for
  // DEB_CICLOS consecutive samples when the counter holds this value.
  localparam logic [CNT_LARG-1:0] CNT_FIM = CNT_LARG'(DEB_CICLOS - 1);
  localparam logic [CNT_LARG-1:0] CNT_UM  = CNT_LARG'(1);

  estado_t             estado_atual;
  estado_t             estado_prox;
  logic [CNT_LARG-1:0] contador;
  logic [CNT_LARG-1:0] contador_prox;
  logic                conf_meta;
  logic                conf_s;
  logic                captura;
  logic                conclui;

  // Two-flop synchroniser bringing the asynchronous button into clk_rapido
  always_ff @(posedge clk_rapido or negedge reset) begin
    if (!reset) begin
      conf_meta <= 1'b0;
      conf_s    <= 1'b0;
    end else begin
      conf_meta <= confirma;
      conf_s    <= conf_meta;
    end
  end

  // State register
  always_ff @(posedge clk_rapido or negedge reset) begin
    if (!reset) begin
      estado_atual <= OCIOSO;
    end else begin
      estado_atual <= estado_prox;
    end
  end

  // Shared debounce counter, used for both press and release qualification
  always_ff @(posedge clk_rapido or negedge reset) begin
    if (!reset) begin
      contador <= '0;
    end else begin
      contador <= contador_prox;
    end
  end

  // Next-state logic; also decides when the switches are captured and when
  // a handshake completes
  always_comb begin
    estado_prox   = estado_atual;
    contador_prox = contador;
    captura       = 1'b0;
    conclui       = 1'b0;
    case (estado_atual)
      OCIOSO: begin
        contador_prox = '0;
        if (WAIT) begin
          // A press already in progress when the request arrives must be
          // released first; it never satisfies this request.
          if (conf_s) begin
            estado_prox = AGUARDA_SOLTAR;
          end else begin
            estado_prox = AGUARDA_PRESS;
          end
        end
      end
      AGUARDA_PRESS: begin
        contador_prox = '0;
        if (!WAIT) begin
          estado_prox = OCIOSO;
        end else if (conf_s) begin
          estado_prox = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!conf_s) begin
          estado_prox   = AGUARDA_PRESS;
          contador_prox = '0;
        end else if (!WAIT) begin
          estado_prox   = OCIOSO;
          contador_prox = '0;
        end else if (contador == CNT_FIM) begin
          estado_prox   = ENTREGA;
          contador_prox = '0;
          captura       = 1'b1;
        end else begin
          contador_prox = contador + CNT_UM;
        end
      end
      ENTREGA: begin
        contador_prox = '0;
        if (!WAIT) begin
          estado_prox = AGUARDA_SOLTAR;
          conclui     = 1'b1;
        end
      end
      AGUARDA_SOLTAR: begin
        // Any bounce back to pressed restarts the release qualification.
        if (conf_s) begin
          contador_prox = '0;
        end else if (contador == CNT_FIM) begin
          estado_prox   = OCIOSO;
          contador_prox = '0;
        end else begin
          contador_prox = contador + CNT_UM;
        end
      end
      default: begin
        estado_prox   = OCIOSO;
        contador_prox = '0;
      end
    endcase
  end

  // READY is registered from the next state so it is glitch-free and drops
  // on the same edge the handshake completes
  always_ff @(posedge clk_rapido or negedge reset) begin
    if (!reset) begin
      READY <= 1'b0;
    end else begin
      READY <= (estado_prox == ENTREGA);
    end
  end

  // Switch word captured only on the accept edge, held until the next accept
  always_ff @(posedge clk_rapido or negedge reset) begin
    if (!reset) begin
      dado_entrada <= '0;
    end else if (captura) begin
      dado_entrada <= {16'h0000, switches};
    end
  end

  // Completed-handshake counter, wraps naturally at 8 bits
  always_ff @(posedge clk_rapido or negedge reset) begin
    if (!reset) begin
      n_leituras <= '0;
    end else if (conclui) begin
      n_leituras <= n_leituras + 8'd1;
    end
  end

  assign estado = estado_atual;

endmodule

// File: tb/tb_controlador_entrada.sv
`timescale 1ns/1ps
// tb_controlador_entrada
// Scoreboard bench: each request pushes the expected word when the press is
// driven; a monitor pops and compares it whenever READY rises, and checks
// the handshake count whenever READY falls.

module tb_controlador_entrada;

  localparam int DEB = 4;

  logic        clk;
  logic        rst_n;
  logic        confirma;
  logic [15:0] switches;
  logic        wait_req;
  logic        ready;
  logic [31:0] dado;
  logic [7:0]  n_leit;
  logic [2:0]  estado;

  int          n_checks;
  int          n_errors;
  logic [31:0] fila_esperada[$];
  logic [7:0]  exp_leituras;
  logic        prev_ready;

  controlador_entrada #(
    .DEB_CICLOS(DEB),
    .CNT_LARG  (4)
  ) dut (
    .clk_rapido  (clk),
    .reset       (rst_n),
    .confirma    (confirma),
    .switches    (switches),
    .WAIT        (wait_req),
    .READY       (ready),
    .dado_entrada(dado),
    .n_leituras  (n_leit),
    .estado      (estado)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado);
    n_checks++;
    if (observado !== esperado) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observado, esperado, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic c, input logic [15:0] sw);
    wait_req = w;
    confirma = c;
    switches = sw;
  endtask

  // Called at the negedge where confirma has just risen with the FSM waiting
  // for a press: the first edge samples it, then 2 sync + DEB debounce edges
  // pass with READY low, and READY is high after the following edge.
  task automatic checkAcceptTiming();
    for (int i = 0; i < DEB + 2; i++) begin
      @(negedge clk);
      checkOutput("ready_antes_aceite", 32'(ready), 32'd0);
    end
    @(negedge clk);
    checkOutput("ready_no_aceite", 32'(ready), 32'd1);
    checkOutput("estado_entrega", 32'(estado), 32'd3);
  endtask

  // CPU drops WAIT, then the button is released and debounced back to idle
  task automatic finishHandshake();
    repeat (2) @(negedge clk);
    wait_req = 1'b0;
    @(negedge clk);
    checkOutput("ready_apos_wait", 32'(ready), 32'd0);
    confirma = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    checkOutput("estado_ocioso", 32'(estado), 32'd0);
  endtask

  task automatic doHandshake(input logic [15:0] sw);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, sw);
    @(negedge clk);
    fila_esperada.push_back({16'h0000, sw});
    confirma = 1'b1;
    checkAcceptTiming();
    finishHandshake();
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready   = 1'b0;
      exp_leituras = 8'd0;
    end else begin
      if (ready && !prev_ready) begin
        if (fila_esperada.size() == 0) begin
          checkOutput("ready_inesperado", 32'(ready), 32'd0);
        end else begin
          checkOutput("dado_entrada", dado, fila_esperada.pop_front());
        end
      end
      if (!ready && prev_ready) begin
        exp_leituras = exp_leituras + 8'd1;
        checkOutput("n_leituras", 32'(n_leit), 32'(exp_leituras));
      end
      prev_ready = ready;
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] sw;
    n_checks     = 0;
    n_errors     = 0;
    prev_ready   = 1'b0;
    exp_leituras = 8'd0;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_dado", dado, 32'd0);
    checkOutput("reset_n_leituras", 32'(n_leit), 32'd0);
    checkOutput("reset_estado", 32'(estado), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic handshake");
    doHandshake(16'hA5C3);
    checkOutput("n_leituras_1", 32'(n_leit), 32'd1);
    checkOutput("dado_mantido", dado, 32'h0000A5C3);

    $display("[TB] bouncing button");
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    @(negedge clk);
    fila_esperada.push_back(32'h00001234);
    confirma = 1'b1;
    repeat (2) @(negedge clk);
    confirma = 1'b0;
    @(negedge clk);
    confirma = 1'b1;
    checkAcceptTiming();
    finishHandshake();

    $display("[TB] button held before request");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0BEE);
    repeat (4) @(negedge clk);
    wait_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("ready_botao_antigo", 32'(ready), 32'd0);
    end
    checkOutput("estado_soltar", 32'(estado), 32'd4);
    confirma = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    fila_esperada.push_back(32'h00000BEE);
    confirma = 1'b1;
    checkAcceptTiming();
    finishHandshake();
    checkOutput("n_leituras_3", 32'(n_leit), 32'd3);

    $display("[TB] button held across two requests");
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h1111);
    @(negedge clk);
    fila_esperada.push_back(32'h00001111);
    confirma = 1'b1;
    checkAcceptTiming();
    repeat (2) @(negedge clk);
    wait_req = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h2222);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("ready_botao_preso", 32'(ready), 32'd0);
    end
    confirma = 1'b0;
    repeat (DEB + 4) @(negedge clk);
    fila_esperada.push_back(32'h00002222);
    confirma = 1'b1;
    checkAcceptTiming();
    finishHandshake();

    $display("[TB] long WAIT with toggling switches");
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h5A5A);
    @(negedge clk);
    fila_esperada.push_back(32'h00005A5A);
    confirma = 1'b1;
    checkAcceptTiming();
    for (int i = 0; i < 1000; i++) begin
      switches = 16'($urandom);
      @(negedge clk);
      checkOutput("ready_mantido", 32'(ready), 32'd1);
      checkOutput("dado_estavel", dado, 32'h00005A5A);
    end
    finishHandshake();
    checkOutput("dado_apos_entrega", dado, 32'h00005A5A);

    $display("[TB] reset during ENTREGA");
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h7777);
    @(negedge clk);
    fila_esperada.push_back(32'h00007777);
    confirma = 1'b1;
    checkAcceptTiming();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_dado", dado, 32'd0);
    checkOutput("rst_n_leituras", 32'(n_leit), 32'd0);
    checkOutput("rst_estado", 32'(estado), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] 256 handshakes for counter wrap");
    for (int k = 0; k < 256; k++) begin
      sw = 16'($urandom);
      doHandshake(sw);
    end
    checkOutput("n_leituras_wrap", 32'(n_leit), 32'd0);
    checkOutput("fila_vazia", 32'(fila_esperada.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
